// File: rtl/load_store_unit_if.sv
// Request/response handshake plus word-wide data-memory port of the load/store unit.
// The slave modport is the unit; the master modport is the pipeline-and-memory side.
interface load_store_unit_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_MemRead_o;
    logic        mem_MemWrite_o;
    logic [31:0] mem_data_i;

    modport slave (
        input  req_valid_i, req_write_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output mem_addr_o, mem_data_o, mem_MemRead_o, mem_MemWrite_o,
        input  mem_data_i
    );

    modport master (
        output req_valid_i, req_write_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  mem_addr_o, mem_data_o, mem_MemRead_o, mem_MemWrite_o,
        output mem_data_i
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: byte/half/word access to a word-wide memory, sub-word stores by RMW.
// Latency accept->rsp: error 1, load 2, word store 2, sub-word store 3; one request in flight, rsp held until accepted.
module load_store_unit #(
    parameter int MEM_BYTES = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    load_store_unit_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic        wr_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word_q, rdata_q;
    logic        accept, rsp_done, req_bad;
    logic [31:0] load_val, store_word, lane_sh, mask, ins;

    assign accept   = bus.req_valid_i && (state_q == IDLE);
    assign rsp_done = (state_q == RSP) && bus.rsp_ready_i;

    // Error decision is made on the live request so the error path skips memory entirely.
    assign req_bad = (bus.req_size_i == 2'b11)
                  || (bus.req_size_i == 2'b01 && bus.req_addr_i[0])
                  || (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00)
                  || ({bus.req_addr_i[31:2], 2'b00} > LAST_WORD);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) begin
                if (req_bad)                     state_d = RSP;
                else if (!bus.req_write_i)       state_d = RD;
                else if (bus.req_size_i == 2'b10) state_d = WR;
                else                             state_d = RD;
            end
            RD:      state_d = wr_q ? WR : RSP;
            WR:      state_d = RSP;
            RSP:     if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load extraction and store merge both work on byte lanes selected by the latched address.
    always_comb begin
        load_val = bus.mem_data_i;
        lane_sh  = '0;
        mask     = 32'hFFFF_FFFF;
        ins      = wdata_q;
        case (size_q)
            2'b00: begin
                lane_sh  = bus.mem_data_i >> {addr_q[1:0], 3'b000};
                load_val = uns_q ? {24'h0, lane_sh[7:0]} : {{24{lane_sh[7]}}, lane_sh[7:0]};
                mask     = 32'h0000_00FF << {addr_q[1:0], 3'b000};
                ins      = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_sh  = bus.mem_data_i >> {addr_q[1], 4'b0000};
                load_val = uns_q ? {16'h0, lane_sh[15:0]} : {{16{lane_sh[15]}}, lane_sh[15:0]};
                mask     = 32'h0000_FFFF << {addr_q[1], 4'b0000};
                ins      = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
        store_word = (word_q & ~mask) | (ins & mask);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    wr_q    <= bus.req_write_i;
                    uns_q   <= bus.req_unsigned_i;
                    size_q  <= bus.req_size_i;
                    addr_q  <= bus.req_addr_i;
                    wdata_q <= bus.req_wdata_i;
                    err_q   <= req_bad;
                    rdata_q <= '0;
                end
                RD: begin
                    word_q <= bus.mem_data_i;
                    if (!wr_q) rdata_q <= load_val;
                end
                RSP: if (rsp_done) begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready_o    = (state_q == IDLE);
    assign bus.rsp_valid_o    = (state_q == RSP);
    assign bus.rsp_rdata_o    = rdata_q;
    assign bus.rsp_err_o      = err_q;
    assign bus.mem_addr_o     = {addr_q[31:2], 2'b00};
    assign bus.mem_MemRead_o  = (state_q == RD);
    assign bus.mem_MemWrite_o = (state_q == WR);
    assign bus.mem_data_o     = (state_q == WR) ? ((size_q == 2'b10) ? wdata_q : store_word) : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 32-byte little-endian byte-array memory model.
module tb_load_store_unit;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   rd_pulses = 0;
    int   lat;
    int   rd_before;
    logic [7:0] mem [0:31];
    int   widx;

    load_store_unit_if bus();

    load_store_unit #(.MEM_BYTES(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    assign widx = int'({bus.mem_addr_o[4:2], 2'b00});
    assign bus.mem_data_i = {mem[widx+3], mem[widx+2], mem[widx+1], mem[widx]};

    always @(posedge clk_i) begin
        if (bus.mem_MemRead_o) rd_pulses <= rd_pulses + 1;
        if (bus.mem_MemWrite_o) begin
            mem[widx]   <= bus.mem_data_o[7:0];
            mem[widx+1] <= bus.mem_data_o[15:8];
            mem[widx+2] <= bus.mem_data_o[23:16];
            mem[widx+3] <= bus.mem_data_o[31:24];
        end
        if (bus.mem_MemRead_o && bus.mem_MemWrite_o) begin
            tests++;
            assert (0) else begin fails++; $error("FAIL rd_wr_overlap: observed both strobes 1, expected at most one"); end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish by 100000, expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk_i);
        bus.req_valid_i    = 1'b1;
        bus.req_write_i    = wr;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wd;
        @(posedge clk_i);
        #1;
        bus.req_valid_i    = 1'b0;
        bus.req_addr_i     = 32'hFFFF_FFFC;
        bus.req_wdata_i    = 32'h0BAD_0BAD;
        bus.req_size_i     = 2'b11;
        lat = 1;
        while (!bus.rsp_valid_o && lat < 10) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk_i);
        bus.rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus.rsp_ready_i = 1'b0;
        chk({tag, "_idle_valid"}, {31'h0, bus.rsp_valid_o}, 32'h0);
        chk({tag, "_idle_rdata"}, bus.rsp_rdata_o, 32'h0);
        chk({tag, "_idle_ready"}, {31'h0, bus.req_ready_o}, 32'h1);
    endtask

    task automatic access(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
        issue(wr, sz, uns, addr, wd);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, bus.rsp_rdata_o, exp_rdata);
        chk({tag, "_err"}, {31'h0, bus.rsp_err_o}, {31'h0, exp_err});
        handshake(tag);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        {mem[3], mem[2], mem[1], mem[0]}     = 32'h1122_3344;
        {mem[31], mem[30], mem[29], mem[28]} = 32'hCAFE_F00D;
        bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_size_i = 2'b00;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;

        #12;
        chk("rst_valid", {31'h0, bus.rsp_valid_o}, 32'h0);
        chk("rst_rdata", bus.rsp_rdata_o, 32'h0);
        chk("rst_err",   {31'h0, bus.rsp_err_o}, 32'h0);
        chk("rst_maddr", bus.mem_addr_o, 32'h0);
        chk("rst_mdata", bus.mem_data_o, 32'h0);
        chk("rst_strobes", {30'h0, bus.mem_MemRead_o, bus.mem_MemWrite_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("rst_ready", {31'h0, bus.req_ready_o}, 32'h1);

        access("sw8", 1'b1, 2'b10, 1'b0, 32'd8, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
        chk("sw8_bytes", {mem[11], mem[10], mem[9], mem[8]}, 32'hDEAD_BEEF);
        chk("sw8_b8", {24'h0, mem[8]}, 32'h0000_00EF);
        access("lw8", 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);

        access("sb2", 1'b1, 2'b00, 1'b0, 32'd2, 32'h1234_56AA, 3, 32'h0, 1'b0);
        chk("sb2_word", {mem[3], mem[2], mem[1], mem[0]}, 32'h11AA_3344);
        access("lbs2", 1'b0, 2'b00, 1'b0, 32'd2, 32'h0, 2, 32'hFFFF_FFAA, 1'b0);
        access("lbu2", 1'b0, 2'b00, 1'b1, 32'd2, 32'h0, 2, 32'h0000_00AA, 1'b0);
        access("sh0", 1'b1, 2'b01, 1'b0, 32'd0, 32'hABCD_8765, 3, 32'h0, 1'b0);
        chk("sh0_word", {mem[3], mem[2], mem[1], mem[0]}, 32'h11AA_8765);
        access("lhs0", 1'b0, 2'b01, 1'b0, 32'd0, 32'h0, 2, 32'hFFFF_8765, 1'b0);
        access("lhu2", 1'b0, 2'b01, 1'b1, 32'd2, 32'h0, 2, 32'h0000_11AA, 1'b0);
        access("lbs11", 1'b0, 2'b00, 1'b0, 32'd11, 32'h0, 2, 32'hFFFF_FFDE, 1'b0);

        rd_before = rd_pulses;
        access("lh3", 1'b0, 2'b01, 1'b0, 32'd3, 32'h0, 1, 32'h0, 1'b1);
        chk("lh3_noread", 32'(rd_pulses - rd_before), 32'h0);
        access("lw28", 1'b0, 2'b10, 1'b0, 32'd28, 32'h0, 2, 32'hCAFE_F00D, 1'b0);
        access("lw32", 1'b0, 2'b10, 1'b0, 32'd32, 32'h0, 1, 32'h0, 1'b1);
        access("lw9",  1'b0, 2'b10, 1'b0, 32'd9, 32'h0, 1, 32'h0, 1'b1);
        access("sz11", 1'b0, 2'b11, 1'b0, 32'd0, 32'h0, 1, 32'h0, 1'b1);
        access("sw32", 1'b1, 2'b10, 1'b0, 32'd32, 32'h5555_5555, 1, 32'h0, 1'b1);
        chk("sw32_w28", {mem[31], mem[30], mem[29], mem[28]}, 32'hCAFE_F00D);

        issue(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
        chk("hold_lat", 32'(lat), 32'd2);
        rd_before = rd_pulses;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            bus.req_valid_i = 1'b1;
            bus.req_write_i = 1'b0;
            bus.req_size_i  = 2'b10;
            bus.req_addr_i  = 32'd28;
            chk("hold_valid", {31'h0, bus.rsp_valid_o}, 32'h1);
            chk("hold_rdata", bus.rsp_rdata_o, 32'hDEAD_BEEF);
            chk("hold_ready", {31'h0, bus.req_ready_o}, 32'h0);
        end
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        handshake("hold");
        @(posedge clk_i);
        #1;
        chk("hold_norsp", {31'h0, bus.rsp_valid_o}, 32'h0);
        chk("hold_noread", 32'(rd_pulses - rd_before), 32'h0);

        @(negedge clk_i);
        bus.req_valid_i = 1'b1; bus.req_write_i = 1'b1; bus.req_size_i = 2'b10;
        bus.req_addr_i = 32'd16; bus.req_wdata_i = 32'h7777_7777;
        @(posedge clk_i);
        #1;
        bus.req_valid_i = 1'b0;
        chk("abort_inwr", {31'h0, bus.mem_MemWrite_o}, 32'h1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("abort_wrdrop", {31'h0, bus.mem_MemWrite_o}, 32'h0);
        chk("abort_maddr", bus.mem_addr_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("abort_ready", {31'h0, bus.req_ready_o}, 32'h1);
        chk("abort_valid", {31'h0, bus.rsp_valid_o}, 32'h0);
        chk("abort_mem16", {mem[19], mem[18], mem[17], mem[16]}, 32'h0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("abort_norsp", {31'h0, bus.rsp_valid_o}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 32, meaning data memory size in bytes (multiple of 4).
REQ-002 SHALL have port clk_i  input  1  clock; all state changes on posedge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  1  pipeline access request valid.
REQ-005 SHALL have port req_ready_o  output  1  unit can accept a request.
REQ-006 SHALL have port req_write_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size_i  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port req_addr_i  input  32  byte address.
REQ-010 SHALL have port req_wdata_i  input  32  store data, right-justified.
REQ-011 SHALL have port rsp_valid_o  output  1  response valid.
REQ-012 SHALL have port rsp_ready_i  input  1  consumer accepts response.
REQ-013 SHALL have port rsp_rdata_o  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err_o  output  1  access rejected (misaligned, illegal size, out of range).
REQ-015 SHALL have ports mem_addr_o  output  32, mem_data_o  output  32, mem_MemRead_o  output  1, mem_MemWrite_o  output  1, all driving the word-wide little-endian data memory.
REQ-016 SHALL have port mem_data_i  input  32  memory read word, combinationally valid for mem_addr_o in the same cycle.

Function
REQ-017 SHALL implement states IDLE, RD, WR, RSP; req_ready_o = 1 only in IDLE.
REQ-018 Accept = req_valid_i && req_ready_o at a posedge; unit SHALL latch write, size, unsigned, addr and wdata on accept.
REQ-019 Error if size==11, halfword with addr[0]==1, word with addr[1:0]!=0, or aligned address > MEM_BYTES-4; on error, IDLE->RSP with rsp_err_o=1 and no memory access.
REQ-020 mem_addr_o SHALL be the latched address with bits [1:0] forced to 0; it holds its value outside RD/WR.
REQ-021 Load: IDLE->RD->RSP; in RD, mem_MemRead_o=1 and mem_data_i is captured at the RD posedge.
REQ-022 Word store: IDLE->WR->RSP; in WR, mem_MemWrite_o=1 and mem_data_o=wdata.
REQ-023 Byte/halfword store SHALL use read-modify-write: IDLE->RD->WR->RSP, merging the wdata low byte or halfword into the captured word at lane addr[1:0] (byte) or addr[1] (halfword); other lanes SHALL be unchanged.
REQ-024 Load extraction: byte = lane addr[1:0], halfword = bits [16*addr[1]+15 : 16*addr[1]]; extend per the latched unsigned flag.
REQ-025 mem_MemRead_o and mem_MemWrite_o SHALL be 0 outside RD and WR respectively and SHALL never both be 1.
REQ-026 Latency from accept edge to rsp_valid_o high: error 1 cycle, load 2 cycles, word store 2 cycles, sub-word store 3 cycles.
REQ-027 In RSP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL hold stable until rsp_valid_o && rsp_ready_i at a posedge, then return to IDLE (rsp_valid_o=0, rdata=0, err=0).
REQ-028 req_valid_i while not ready SHALL be ignored; a new request is accepted no earlier than the cycle after the response handshake.
REQ-029 Input changes after accept SHALL NOT affect the in-flight access.

Reset
REQ-030 When rst_i=0, the unit SHALL asynchronously enter IDLE with rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_addr_o=0, mem_data_o=0, mem_MemRead_o=0, mem_MemWrite_o=0.
REQ-031 req_ready_o SHALL be 1 after reset release.
REQ-032 Reset during RD or WR SHALL abort the access, de-assert MemWrite immediately, and produce no response.

Verification
REQ-033 Word store addr 8, data 0xDEADBEEF, then load word addr 8 -> memory bytes 8..11 = EF BE AD DE; load rsp_rdata_o=0xDEADBEEF; each response 2 cycles after accept.
REQ-034 Memory word 0 = 0x11223344; store byte 0xAA to addr 2 -> word 0x11AA3344; signed load byte addr 2 -> 0xFFFFFFAA; unsigned load byte addr 2 -> 0x000000AA.
REQ-035 Halfword load addr 3 -> rsp_err_o=1 after 1 cycle, no MemRead pulse; word load addr 28 with MEM_BYTES=32 -> ok; word load addr 32 -> err=1.
REQ-036 Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stable; req_ready_o=0 throughout; new req_valid_i ignored.
REQ-037 Assert rst_i=0 mid-WR -> MemWrite drops without waiting for a clock edge; after release req_ready_o=1 and rsp_valid_o=0.
